// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI definitions (mode encodings, byte width, receive
//                FSM states and sample-edge selection) used by the SPI slave
//                receiver and the SPI master driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Byte width on the wire and matching bit-counter width
    localparam int BYTE_W = 8;
    localparam int BITCNT_W = 3;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Receive frame states
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } rx_state_e;

    // Data is sampled on the rising SCLK edge when CPOL and CPHA agree,
    // and on the falling edge otherwise.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_input_sync
//  Description : Multi-bit level synchronizer with rise/fall strobes. All bits
//                travel through the same number of stages so that related
//                signals (SCLK/MOSI/CS) stay mutually aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_input_sync #(
    parameter int                WIDTH       = 3,
    parameter int                SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // Stage 0 is the first flop after the pins; the last stage is the
    // synchronized level seen by the rest of the design.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [WIDTH-1:0]                  prev_q;

    // Synchronizer chain plus one-cycle-delayed copy for edge detection.
    // Resetting to the idle levels keeps a reset from looking like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
            prev_q  <= stage_q[SYNC_STAGES-1];
        end
    end

    assign level_o = stage_q[SYNC_STAGES-1];
    assign rise_o  = stage_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~stage_q[SYNC_STAGES-1] & prev_q;

endmodule : spi_input_sync
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_rx
//  Description : Receive-side SPI slave. Oversamples SCLK/MOSI/CS in the
//                system clock domain, assembles MSB-first bytes and presents
//                them on a valid/ready interface with overrun and frame
//                status reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SPI_SCLK,
    input  logic              SPI_MOSI,
    input  logic              SPI_CS,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              frame_active,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [7:0]        byte_count
);

    // Bit positions inside the synchronizer bundle
    localparam int IDX_SCLK = 0;
    localparam int IDX_MOSI = 1;
    localparam int IDX_CS   = 2;

    // Idle levels: SCLK at CPOL, MOSI low, CS deasserted
    localparam logic [2:0] SYNC_RESET_VAL = {1'b1, 1'b0, CPOL};
    localparam logic       SAMPLE_RISE    = sample_on_rise(CPOL, CPHA);
    localparam logic [7:0] BYTE_CNT_MAX   = 8'hFF;

    logic [2:0] sync_level;
    logic [2:0] sync_rise;
    logic [2:0] sync_fall;

    logic       mosi_s;
    logic       cs_fall;
    logic       cs_rise;
    logic       sample_edge;

    rx_state_e           state_q, state_d;
    logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                overrun_q, overrun_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic [7:0]          byte_cnt_q, byte_cnt_d;

    logic [BYTE_W-1:0]   assembled;
    logic                byte_done;
    logic                unused_sync;

    spi_input_sync #(
        .WIDTH       (3),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (SYNC_RESET_VAL)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i ({SPI_CS, SPI_MOSI, SPI_SCLK}),
        .level_o (sync_level),
        .rise_o  (sync_rise),
        .fall_o  (sync_fall)
    );

    assign mosi_s      = sync_level[IDX_MOSI];
    assign cs_fall     = sync_fall[IDX_CS];
    assign cs_rise     = sync_rise[IDX_CS];
    assign sample_edge = SAMPLE_RISE ? sync_rise[IDX_SCLK] : sync_fall[IDX_SCLK];

    // MOSI edges and the raw SCLK/CS levels are not needed here
    assign unused_sync = ^{sync_level[IDX_SCLK], sync_level[IDX_CS],
                           sync_rise[IDX_MOSI], sync_fall[IDX_MOSI]};

    // Byte as it would look after shifting in the current MOSI sample
    assign assembled = {shift_q[BYTE_W-2:0], mosi_s};

    // Next-state, datapath and status-pulse logic
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        byte_cnt_d = byte_cnt_q;
        overrun_d  = 1'b0;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        byte_done  = 1'b0;

        // A consumed byte frees the holding register unless a new byte
        // lands in the same cycle (handled below).
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    byte_cnt_d = '0;
                end
            end
            ST_ACTIVE: begin
                // CS release takes priority over a coincident sampling edge
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    abort_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (sample_edge) begin
                    shift_d   = assembled;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    byte_done = (bit_cnt_q == 3'd7);
                end
            end
        endcase

        if (byte_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = assembled;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
            if (byte_cnt_q != BYTE_CNT_MAX) begin
                byte_cnt_d = byte_cnt_q + 8'd1;
            end
        end
    end

    // Frame state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register, holding register and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign overrun      = overrun_q;
    assign frame_active = (state_q == ST_ACTIVE);
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign byte_count   = byte_cnt_q;

endmodule : spi_slave_rx
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_rx
//  Description : Self-checking bench for spi_slave_rx. Instance 0 runs mode 0,
//                instance 1 runs mode 3. A frame-level reference model
//                predicts accepted bytes, overruns and frame status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk     [2];
    logic       mosi     [2];
    logic       cs       [2];
    logic       ready    [2];
    logic [7:0] rx_data  [2];
    logic       rx_valid [2];
    logic       overrun  [2];
    logic       f_active [2];
    logic       f_done   [2];
    logic       f_abort  [2];
    logic [7:0] b_count  [2];

    always #5 clk = ~clk;

    spi_slave_rx #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(SYNC)) u_dut0 (
        .clk(clk), .reset(reset), .SPI_SCLK(sclk[0]), .SPI_MOSI(mosi[0]),
        .SPI_CS(cs[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .rx_ready(ready[0]), .overrun(overrun[0]), .frame_active(f_active[0]),
        .frame_done(f_done[0]), .frame_abort(f_abort[0]), .byte_count(b_count[0])
    );

    spi_slave_rx #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(SYNC)) u_dut3 (
        .clk(clk), .reset(reset), .SPI_SCLK(sclk[1]), .SPI_MOSI(mosi[1]),
        .SPI_CS(cs[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .rx_ready(ready[1]), .overrun(overrun[1]), .frame_active(f_active[1]),
        .frame_done(f_done[1]), .frame_abort(f_abort[1]), .byte_count(b_count[1])
    );

    // ---------------- monitor (observed events) ----------------
    int         obs_n   [2] = '{0, 0};
    logic [7:0] obs_data[2][0:1023];
    int         ovr_n   [2] = '{0, 0};
    int         done_n  [2] = '{0, 0};
    int         abort_n [2] = '{0, 0};
    int         lone_n  [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rx_valid[i] && ready[i]) begin
                obs_data[i][obs_n[i] & 1023] <= rx_data[i];
                obs_n[i] <= obs_n[i] + 1;
            end
            if (overrun[i]) ovr_n[i] <= ovr_n[i] + 1;
            if (f_done[i])  done_n[i] <= done_n[i] + 1;
            if (f_abort[i]) abort_n[i] <= abort_n[i] + 1;
            if (f_abort[i] && !f_done[i]) lone_n[i] <= lone_n[i] + 1;
        end
    end

    // ---------------- reference model state ----------------
    int         checks = 0;
    int         errors = 0;
    int         exp_n    [2] = '{0, 0};
    logic [7:0] exp_data [2][0:1023];
    int         rd_n     [2] = '{0, 0};
    bit         hold_full[2] = '{1'b0, 1'b0};
    logic [7:0] hold_data[2];
    logic [7:0] tx       [0:299];
    int         s_ovr, s_done, s_abort, s_lone;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic push_exp(input int idx, input logic [7:0] b);
        exp_data[idx][exp_n[idx] & 1023] = b;
        exp_n[idx]++;
    endtask

    task automatic snap(input int idx);
        s_ovr   = ovr_n[idx];
        s_done  = done_n[idx];
        s_abort = abort_n[idx];
        s_lone  = lone_n[idx];
    endtask

    // Every byte the model says was accepted must appear, in order
    task automatic check_hs(input int idx);
        check_val("hs_count", obs_n[idx], exp_n[idx]);
        for (int k = rd_n[idx]; k < exp_n[idx] && k < obs_n[idx]; k++)
            check_val("hs_data", int'(obs_data[idx][k & 1023]), int'(exp_data[idx][k & 1023]));
        rd_n[idx] = exp_n[idx];
    endtask

    task automatic check_frame(input int idx, input int exp_bc, input bit exp_abort, input int exp_ovr);
        check_hs(idx);
        check_val("overruns", ovr_n[idx] - s_ovr, exp_ovr);
        check_val("done_pulses", done_n[idx] - s_done, 1);
        check_val("abort_pulses", abort_n[idx] - s_abort, int'(exp_abort));
        check_val("abort_without_done", lone_n[idx] - s_lone, 0);
        check_val("byte_count", int'(b_count[idx]), exp_bc);
        check_val("frame_active_end", int'(f_active[idx]), 0);
        check_val("rx_valid", int'(rx_valid[idx]), int'(hold_full[idx]));
        if (hold_full[idx]) check_val("rx_data_held", int'(rx_data[idx]), int'(hold_data[idx]));
    endtask

    // Consume whatever sits in the holding register
    task automatic drain(input int idx);
        if (hold_full[idx]) begin
            push_exp(idx, hold_data[idx]);
            hold_full[idx] = 1'b0;
            ready[idx] = 1'b1;
            tick();
            ready[idx] = 1'b0;
            tick();
            check_hs(idx);
            check_val("rx_valid_drained", int'(rx_valid[idx]), 0);
        end
    endtask

    // Raise ready for exactly the cycle in which the byte just sampled completes
    task automatic ready_pulse0();
        repeat (SYNC) tick();
        ready[0] = 1'b1;
        tick();
        ready[0] = 1'b0;
    endtask

    // One bit as the master driver produces it; instance idx uses CPOL=CPHA=idx
    task automatic send_bit(input int idx, input logic b, input int h, input bit pulse);
        logic pol;
        pol = (idx == 1);
        if (!pol) begin
            mosi[idx] = b;
            wait_cyc(h);
            sclk[idx] = ~pol;
            if (pulse) fork ready_pulse0(); join_none
            wait_cyc(h);
            sclk[idx] = pol;
        end else begin
            sclk[idx] = ~pol;
            mosi[idx] = b;
            wait_cyc(h);
            sclk[idx] = pol;
            if (pulse) fork ready_pulse0(); join_none
            wait_cyc(h);
        end
    endtask

    task automatic send_frame(input int idx, input int nbytes, input int tail, input int h,
                              input bit pulse_last, input bit raise_cs);
        logic [7:0] cur;
        cs[idx] = 1'b0;
        wait_cyc(SYNC + 2);
        check_val("frame_active_start", int'(f_active[idx]), 1);
        check_val("byte_count_start", int'(b_count[idx]), 0);
        for (int n = 0; n < nbytes; n++) begin
            cur = tx[n];
            for (int b = 7; b >= 0; b--)
                send_bit(idx, cur[b], h, pulse_last && (n == nbytes - 1) && (b == 0));
        end
        cur = tx[nbytes];
        for (int b = 0; b < tail; b++)
            send_bit(idx, cur[7 - b], h, 1'b0);
        if (raise_cs) begin
            wait_cyc(h);
            cs[idx] = 1'b1;
            wait_cyc(SYNC + 3);
        end
    endtask

    // Frame with a fixed ready level; model predicts acceptance and overruns
    task automatic run_frame(input int idx, input int nbytes, input int tail, input bit rdy, input int h);
        int ovr = 0;
        snap(idx);
        for (int n = 0; n < nbytes; n++) begin
            if (rdy) push_exp(idx, tx[n]);
            else if (!hold_full[idx]) begin
                hold_full[idx] = 1'b1;
                hold_data[idx] = tx[n];
            end else ovr++;
        end
        ready[idx] = rdy;
        send_frame(idx, nbytes, tail, h, 1'b0, 1'b1);
        ready[idx] = 1'b0;
        check_frame(idx, (nbytes > 255) ? 255 : nbytes, tail != 0, ovr);
        drain(idx);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int nb, tl, hh, ix;
        bit rd;
        sclk[0] = 1'b0; sclk[1] = 1'b1;
        mosi[0] = 1'b0; mosi[1] = 1'b0;
        cs[0] = 1'b1;   cs[1] = 1'b1;
        ready[0] = 1'b0; ready[1] = 1'b0;
        reset = 1'b1;
        wait_cyc(4);
        for (int i = 0; i < 2; i++) begin
            check_val("rst_rx_data", int'(rx_data[i]), 0);
            check_val("rst_rx_valid", int'(rx_valid[i]), 0);
            check_val("rst_overrun", int'(overrun[i]), 0);
            check_val("rst_frame_active", int'(f_active[i]), 0);
            check_val("rst_frame_done", int'(f_done[i]), 0);
            check_val("rst_frame_abort", int'(f_abort[i]), 0);
            check_val("rst_byte_count", int'(b_count[i]), 0);
        end
        reset = 1'b0;
        wait_cyc(SYNC + 3);
        check_val("no_false_frame", int'(f_active[0]) + int'(f_active[1]) + done_n[0] + done_n[1], 0);

        // Mode 0, two bytes, always ready
        tx[0] = 8'hA5; tx[1] = 8'h3C;
        run_frame(0, 2, 0, 1'b1, 2);

        // Not ready: first byte held, the rest overrun
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
        run_frame(0, 3, 0, 1'b0, 2);

        // Partial byte aborted, then a clean byte
        tx[0] = 8'hF0;
        run_frame(0, 0, 5, 1'b1, 2);
        tx[0] = 8'h5A;
        run_frame(0, 1, 0, 1'b1, 3);

        // Mode 3: SCLK activity with CS high is ignored, then one byte
        snap(1);
        for (int k = 0; k < 6; k++) begin
            sclk[1] = ~sclk[1];
            mosi[1] = ~mosi[1];
            wait_cyc(3);
        end
        wait_cyc(SYNC + 2);
        check_hs(1);
        check_val("idle_sclk_valid", int'(rx_valid[1]), 0);
        check_val("idle_sclk_done", done_n[1] - s_done, 0);
        tx[0] = 8'h81;
        run_frame(1, 1, 0, 1'b1, 2);

        // Reset in the middle of a frame
        tx[0] = 8'hE0;
        send_frame(0, 0, 3, 2, 1'b0, 1'b0);
        reset = 1'b1;
        wait_cyc(2);
        check_val("midrst_frame_active", int'(f_active[0]), 0);
        check_val("midrst_rx_valid", int'(rx_valid[0]), 0);
        check_val("midrst_byte_count", int'(b_count[0]), 0);
        check_val("midrst_rx_data", int'(rx_data[0]), 0);
        check_val("midrst_pulses", int'(overrun[0]) + int'(f_done[0]) + int'(f_abort[0]), 0);
        cs[0] = 1'b1;
        tick();
        snap(0);
        reset = 1'b0;
        wait_cyc(SYNC + 3);
        check_val("postrst_no_done", done_n[0] - s_done, 0);
        tx[0] = 8'hC3;
        run_frame(0, 1, 0, 1'b0, 2);

        // Ready raised exactly when the second byte completes
        tx[0] = 8'h01; tx[1] = 8'h02;
        snap(0);
        push_exp(0, 8'h01);
        hold_full[0] = 1'b1;
        hold_data[0] = 8'h02;
        send_frame(0, 2, 0, 2, 1'b1, 1'b1);
        check_frame(0, 2, 1'b0, 0);
        drain(0);

        // Randomized frames on both modes
        for (int f = 0; f < 16; f++) begin
            ix = f % 2;
            nb = int'($urandom_range(4, 1));
            tl = ($urandom_range(1, 0) == 1) ? int'($urandom_range(7, 1)) : 0;
            hh = int'($urandom_range(4, 2));
            rd = ($urandom_range(1, 0) == 1);
            for (int n = 0; n <= nb; n++) tx[n] = 8'($urandom);
            run_frame(ix, nb, tl, rd, hh);
        end

        // byte_count saturation
        for (int n = 0; n < 258; n++) tx[n] = 8'($urandom);
        run_frame(0, 257, 0, 1'b1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_slave_rx
`default_nettype wire
